// File: rtl/nettlp_pkg.sv
// nettlp_pkg: shared types and constants for the PCIe transmit drain.
//   PCIE_TX_AXIS_T  - one AXI4-Stream beat toward the 7-series PCIe core.
//   PCIE_FIFO64_TX  - one TLP FIFO entry as written by the Ethernet decap stage.
//   tx_state_e      - drain FSM states.
package nettlp_pkg;

  // tuser layout toward the core is {src_dsc, str, err_fwd, ecrc_gen}
  localparam int TX_TUSER_SRC_DSC = 3;
  localparam int TX_TUSER_STR     = 2;

  // 512 B payload plus header, in 8-byte beats
  localparam logic [7:0] TX_MAX_BEATS  = 8'd66;
  localparam logic [7:0] TX_TRUNC_KEEP = 8'h0F;

  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [7:0]  tkeep;
    logic [63:0] tdata;
    logic [3:0]  tuser;
  } PCIE_TX_AXIS_T;

  typedef struct packed {
    logic          data_valid;
    PCIE_TX_AXIS_T tlp;
  } PCIE_FIFO64_TX;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_DATA = 2'd1,
    TX_DROP = 2'd2
  } tx_state_e;

  // The decap stage marks a forced-tlast error with an all-zero byte enable.
  function automatic logic is_abort_entry(input PCIE_FIFO64_TX e);
    return e.data_valid && e.tlp.tlast && (e.tlp.tkeep == 8'h00);
  endfunction

endpackage

// File: rtl/axis_tx_outreg.sv
// axis_tx_outreg: 1-deep registered output stage toward the PCIe core.
//   clk, rst   - clock and asynchronous active-high reset
//   src_empty  - FIFO empty flag
//   pop        - pop request to the FIFO (register free or draining this cycle)
//   load       - write load_beat into the register (only meaningful with pop)
//   load_beat  - beat to present; tvalid is forced high on load
//   tready     - core ready
//   out_beat   - registered beat driven to the core
module axis_tx_outreg
  import nettlp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          src_empty,
  output logic          pop,
  input  logic          load,
  input  PCIE_TX_AXIS_T load_beat,
  input  logic          tready,
  output PCIE_TX_AXIS_T out_beat
);

  PCIE_TX_AXIS_T out_r;

  // Pop whenever the register is empty or its beat leaves this cycle; held low in reset.
  assign pop = !rst && !src_empty && (!out_r.tvalid || tready);

  // Output register: reload on a forwarded pop, clear after accept, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= '0;
    end else if (load) begin
      out_r        <= load_beat;
      out_r.tvalid <= 1'b1;
    end else if (tready) begin
      out_r <= '0;
    end else begin
      out_r <= out_r;
    end
  end

  assign out_beat = out_r;

endmodule

// File: rtl/pcie_tx_drain.sv
// pcie_tx_drain: drains the FWFT TLP FIFO into the 7-series PCIe AXIS tx port.
//   pcie_clk, pcie_rst        - user clock, asynchronous active-high reset
//   fifo_rd_en/dout/empty     - FWFT FIFO read side
//   s_axis_tx_*               - AXI4-Stream transmit interface (registered)
//   tx_pkt_count              - TLPs completed normally
//   tx_abort_count            - TLPs terminated with src_dsc
// Bubbles are dropped, abort entries become discontinued TLPs, and packets
// longer than MAX_BEATS are cut and the remainder discarded.
module pcie_tx_drain
  import nettlp_pkg::*;
#(
  parameter logic [7:0] MAX_BEATS  = TX_MAX_BEATS,
  parameter logic [7:0] TRUNC_KEEP = TX_TRUNC_KEEP
)
(
  input  logic          pcie_clk,
  input  logic          pcie_rst,
  output logic          fifo_rd_en,
  input  PCIE_FIFO64_TX fifo_dout,
  input  logic          fifo_empty,
  output logic          s_axis_tx_tvalid,
  input  logic          s_axis_tx_tready,
  output logic          s_axis_tx_tlast,
  output logic [7:0]    s_axis_tx_tkeep,
  output logic [63:0]   s_axis_tx_tdata,
  output logic [3:0]    s_axis_tx_tuser,
  output logic [31:0]   tx_pkt_count,
  output logic [15:0]   tx_abort_count
);

  tx_state_e     state_r, state_s;
  logic [7:0]    beat_cnt_r, beat_cnt_s, beat_nxt_s;
  logic          pop_s, load_s, pkt_inc_s, abort_inc_s, is_abort_s;
  PCIE_TX_AXIS_T load_beat_s, out_beat_s;
  logic [31:0]   pkt_cnt_r;
  logic [15:0]   abort_cnt_r;

  axis_tx_outreg u_outreg (
    .clk       (pcie_clk),
    .rst       (pcie_rst),
    .src_empty (fifo_empty),
    .pop       (pop_s),
    .load      (load_s),
    .load_beat (load_beat_s),
    .tready    (s_axis_tx_tready),
    .out_beat  (out_beat_s)
  );

  assign is_abort_s = is_abort_entry(fifo_dout);
  assign beat_nxt_s = beat_cnt_r + 8'd1;

  // Next-state, beat counter and load selection for each popped entry.
  always_comb begin
    state_s          = state_r;
    beat_cnt_s       = beat_cnt_r;
    load_s           = 1'b0;
    pkt_inc_s        = 1'b0;
    abort_inc_s      = 1'b0;
    load_beat_s      = fifo_dout.tlp;
    load_beat_s.tuser = 4'b0000;
    // Bubbles fall through here: popped, nothing else changes.
    if (pop_s && fifo_dout.data_valid) begin
      case (state_r)
        TX_IDLE: begin
          if (is_abort_s) begin
            state_s = TX_IDLE;
          end else begin
            load_s = 1'b1;
            if (fifo_dout.tlp.tlast) begin
              pkt_inc_s  = 1'b1;
              beat_cnt_s = 8'd0;
            end else begin
              beat_cnt_s = 8'd1;
              state_s    = TX_DATA;
            end
          end
        end
        TX_DATA: begin
          load_s = 1'b1;
          if (is_abort_s) begin
            // Replace the error marker with a synthesized discontinue beat.
            load_beat_s.tdata                   = 64'h0;
            load_beat_s.tkeep                   = TRUNC_KEEP;
            load_beat_s.tlast                   = 1'b1;
            load_beat_s.tuser[TX_TUSER_SRC_DSC] = 1'b1;
            abort_inc_s = 1'b1;
            beat_cnt_s  = 8'd0;
            state_s     = TX_IDLE;
          end else if (fifo_dout.tlp.tlast) begin
            pkt_inc_s  = 1'b1;
            beat_cnt_s = 8'd0;
            state_s    = TX_IDLE;
          end else if (beat_nxt_s == MAX_BEATS) begin
            // Runaway packet: close it as discontinued, then swallow the rest.
            load_beat_s.tlast                   = 1'b1;
            load_beat_s.tuser[TX_TUSER_SRC_DSC] = 1'b1;
            abort_inc_s = 1'b1;
            beat_cnt_s  = beat_nxt_s;
            state_s     = TX_DROP;
          end else begin
            beat_cnt_s = beat_nxt_s;
          end
        end
        TX_DROP: begin
          if (fifo_dout.tlp.tlast) begin
            beat_cnt_s = 8'd0;
            state_s    = TX_IDLE;
          end else begin
            state_s = TX_DROP;
          end
        end
        default: begin
          beat_cnt_s = 8'd0;
          state_s    = TX_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM state and beat counter.
  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      state_r    <= TX_IDLE;
      beat_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_s;
      beat_cnt_r <= beat_cnt_s;
    end
  end

  // Completed and aborted TLP counters, wrapping.
  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      pkt_cnt_r   <= 32'd0;
      abort_cnt_r <= 16'd0;
    end else begin
      pkt_cnt_r   <= pkt_inc_s   ? pkt_cnt_r + 32'd1   : pkt_cnt_r;
      abort_cnt_r <= abort_inc_s ? abort_cnt_r + 16'd1 : abort_cnt_r;
    end
  end

  assign fifo_rd_en       = pop_s;
  assign s_axis_tx_tvalid = out_beat_s.tvalid;
  assign s_axis_tx_tlast  = out_beat_s.tlast;
  assign s_axis_tx_tkeep  = out_beat_s.tkeep;
  assign s_axis_tx_tdata  = out_beat_s.tdata;
  assign s_axis_tx_tuser  = out_beat_s.tuser;
  assign tx_pkt_count     = pkt_cnt_r;
  assign tx_abort_count   = abort_cnt_r;

endmodule
